// File: rtl/multiply_control.sv
// Sequencer for a shift-and-add multiplier: walks the multiplier bits via
// product_lsb and issues load/add/shift strobes, all driven straight from flops.
module multiply_control #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic          product_lsb,
    output logic          w_ctrl_Multiplicand,
    output logic          w_ctrl_Product,
    output logic          add_en,
    output logic          shift_en,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        TEST,
        ADD,
        SHIFT,
        DONE
    } state_e;

    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] iter_q, iter_d;
    logic          load_q, add_q, shift_q, busy_q, done_q;

    always_comb begin
        // NOTE: defaults first so every path assigns every signal; no latches.
        state_d = state_q;
        iter_d  = iter_q;
        // Abort outranks start even in IDLE; DONE always completes its pulse.
        if (abort && state_q != DONE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        state_d = LOAD;
                        iter_d  = '0;
                    end
                end
                LOAD:  state_d = TEST;
                TEST:  state_d = product_lsb ? ADD : SHIFT;
                ADD:   state_d = SHIFT;
                SHIFT: begin
                    iter_d  = iter_q + CW'(1);
                    state_d = (iter_q == LAST_ITER) ? DONE : TEST;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state and registered, so each one is
    // high exactly while the FSM sits in its state and comes from a flop.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            iter_q  <= '0;
            load_q  <= 1'b0;
            add_q   <= 1'b0;
            shift_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            load_q  <= (state_d == LOAD);
            add_q   <= (state_d == ADD);
            shift_q <= (state_d == SHIFT);
            busy_q  <= (state_d != IDLE);
            done_q  <= (state_d == DONE);
        end
    end

    assign w_ctrl_Multiplicand = load_q;
    assign w_ctrl_Product      = load_q;
    assign add_en              = add_q;
    assign shift_en            = shift_q;
    assign busy                = busy_q;
    assign done                = done_q;
    assign iter_count          = iter_q;

endmodule

// File: tb/tb_multiply_control.sv
// Self-checking bench for multiply_control: a modelled datapath closes the
// loop and results are judged against a*b, popcount latency and bit positions.
module tb_multiply_control;

    localparam int W  = 32;
    localparam int CW = $clog2(W) + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          product_lsb;
    logic          w_ctrl_Multiplicand;
    logic          w_ctrl_Product;
    logic          add_en;
    logic          shift_en;
    logic          busy;
    logic          done;
    logic [CW-1:0] iter_count;

    int errors = 0;
    int checks = 0;

    multiply_control #(.WIDTH(W)) dut (
        .clk                (clk),
        .rst                (rst),
        .start              (start),
        .abort              (abort),
        .product_lsb        (product_lsb),
        .w_ctrl_Multiplicand(w_ctrl_Multiplicand),
        .w_ctrl_Product     (w_ctrl_Product),
        .add_en             (add_en),
        .shift_en           (shift_en),
        .busy               (busy),
        .done               (done),
        .iter_count         (iter_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath fixture: multiplicand register and product register with carry.
    logic [W-1:0] mplier_val, mcand_val, mcand_q;
    logic [2*W:0] prod_q;

    always @(posedge clk) begin
        if (w_ctrl_Multiplicand) mcand_q <= mcand_val;
        if (w_ctrl_Product) prod_q <= {(W + 1)'(0), mplier_val};
        else if (add_en) prod_q[2*W:W] <= {1'b0, prod_q[2*W-1:W]} + {1'b0, mcand_q};
        else if (shift_en) prod_q <= prod_q >> 1;
    end
    assign product_lsb = prod_q[0];

    function automatic logic [6:0] outs();
        return {w_ctrl_Multiplicand, w_ctrl_Product, add_en, shift_en, busy, done, |iter_count};
    endfunction

    task automatic expect_int(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Runs one multiply from IDLE and checks it against the arithmetic reference.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string tag,
                          input bit inject_start);
        int p, cyc, adds, shifts, loads, done_cyc, overlap, order_err, busy_err, extra_done;
        logic [W-1:0]   add_mask;
        logic [2*W-1:0] exp_prod;
        logic           prev_add, got_done;
        logic [CW-1:0]  iter_at_done;
        p = $countones(a);
        exp_prod = 64'(a) * 64'(b);
        mplier_val = a;
        mcand_val = b;
        {adds, shifts, loads, done_cyc, overlap, order_err, busy_err, extra_done} = '0;
        add_mask = '0;
        prev_add = 1'b0;
        got_done = 1'b0;
        iter_at_done = '0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        checks++;
        if (!(w_ctrl_Multiplicand && w_ctrl_Product && iter_count == 0)) begin
            errors++;
            $display("FAIL %s load_cycle1: mc=%0b pr=%0b iter=%0d expected 1 1 0", tag,
                     w_ctrl_Multiplicand, w_ctrl_Product, iter_count);
        end
        while (!got_done && cyc <= 300) begin
            start = 1'b0;
            if (w_ctrl_Multiplicand) loads++;
            if (w_ctrl_Multiplicand !== w_ctrl_Product) overlap++;
            if (add_en && shift_en) overlap++;
            if (prev_add && !shift_en) order_err++;
            if (add_en) begin
                adds++;
                if (shifts < W) add_mask[shifts] = 1'b1;
            end
            if (shift_en) begin
                shifts++;
                if (inject_start && shifts == 6) start = 1'b1;
            end
            if (!busy) busy_err++;
            if (done) begin
                got_done = 1'b1;
                done_cyc = cyc;
                iter_at_done = iter_count;
            end
            prev_add = add_en;
            if (!got_done) begin
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        expect_int({tag, " done_seen"}, longint'(got_done), 1);
        expect_int({tag, " done_cycle"}, done_cyc, 2 * W + 2 + p);
        expect_int({tag, " iter_at_done"}, iter_at_done, W);
        expect_int({tag, " add_count"}, adds, p);
        expect_int({tag, " shift_count"}, shifts, W);
        expect_int({tag, " add_positions"}, add_mask, a);
        expect_int({tag, " load_cycles"}, loads, 1);
        expect_int({tag, " strobe_overlap"}, overlap, 0);
        expect_int({tag, " add_then_shift"}, order_err, 0);
        expect_int({tag, " busy_held"}, busy_err, 0);
        expect_int({tag, " product"}, prod_q[2*W-1:0], exp_prod);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        expect_int({tag, " quiet_after_done"}, extra_done, 0);
        expect_int({tag, " iter_held_idle"}, iter_count, W);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        mplier_val = '0;
        mcand_val = '0;
        repeat (2) @(negedge clk);
        expect_int("reset_outputs", outs(), 0);
        start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        expect_int("idle_after_reset", outs(), 0);
    endtask

    task automatic test_directed();
        run_op(32'h0000_0000, 32'h1234_5678, "zero", 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, "ones", 1'b0);
        run_op(32'h0000_0005, 32'h0000_0007, "five", 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 6; i++) begin
            run_op($urandom, $urandom, $sformatf("rand%0d", i), 1'b0);
        end
    endtask

    task automatic test_start_ignored();
        run_op($urandom, $urandom, "start_mid", 1'b1);
    endtask

    task automatic test_abort();
        int n, dones;
        mplier_val = $urandom;
        mcand_val = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (iter_count != 10 && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_int("abort_reach_iter10", iter_count, 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        expect_int("abort_outputs", {w_ctrl_Product, add_en, shift_en, busy, done}, 0);
        expect_int("abort_iter_hold", iter_count, 10);
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (done || busy) dones++;
        end
        expect_int("abort_no_done", dones, 0);
        expect_int("abort_iter_still", iter_count, 10);
        run_op($urandom, $urandom, "after_abort", 1'b0);
    endtask

    task automatic test_async_reset();
        int n;
        mplier_val = 32'hFFFF_FFFF;
        mcand_val = $urandom;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!add_en && n < 20) begin
            @(negedge clk);
            n++;
        end
        expect_int("reach_add", add_en, 1);
        #2 rst = 1'b0;
        #1;
        expect_int("async_reset_outputs", outs(), 0);
        @(negedge clk);
        expect_int("reset_held_outputs", outs(), 0);
        rst = 1'b1;
        run_op($urandom, $urandom, "after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        int n;
        mplier_val = '0;
        mcand_val = $urandom;
        start = 1'b1;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_int("b2b_first_done", done, 1);
        @(negedge clk);
        expect_int("b2b_idle_gap", {busy, w_ctrl_Product}, 0);
        @(negedge clk);
        expect_int("b2b_reload", {busy, w_ctrl_Multiplicand, w_ctrl_Product, iter_count}, {3'b111, CW'(0)});
        start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        expect_int("b2b_second_done", done, 1);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
